// File: rtl/pattern_pkg.sv
// Constants shared between the bit-stream serializer and the downstream pattern detector.
package pattern_pkg;

    // Serializer FSM encoding
    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    // Stream symbols as seen by the detector
    localparam logic B = 1'b0;
    localparam logic C = 1'b1;

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Parallel word handshake into the serializer: data/load from the producer, ready back.
interface bit_stream_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] data_i;
    logic             load_i;
    logic             ready_o;

    modport master (output data_i, output load_i, input  ready_o);
    modport slave  (input  data_i, input  load_i, output ready_o);
endinterface

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial stage feeding the pattern detector; a one-word hold register
// lets consecutive words stream out with no bubble between them.
module bit_stream_serializer
    import pattern_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    bit_stream_serializer_if.slave   bus,
    input  logic                     en_i,
    output logic                     d_o,
    output logic                     valid_o,
    output logic                     last_o,
    output logic                     busy_o
);

    localparam int unsigned     CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic             state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_d, valid_d, last_d, busy_d;

    logic             accept;
    logic             cur_bit;
    logic             cnt_last;
    logic             last_emit;
    logic [WIDTH-1:0] shift_adv;

    // Hold register free and not in reset
    assign bus.ready_o = ~rst & ~hold_full_q;
    assign accept      = bus.load_i & bus.ready_o;
    assign cnt_last    = (cnt_q == CNT_LAST);
    assign last_emit   = (state_q == S_SHIFT) & en_i & cnt_last;

    always_comb begin
        cur_bit   = shift_q[0];
        shift_adv = {B, shift_q[WIDTH-1:1]};
        if (MSB_FIRST) begin
            cur_bit   = shift_q[WIDTH-1];
            shift_adv = {shift_q[WIDTH-2:0], B};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SHIFT;
            S_SHIFT: if (last_emit && !hold_full_q && !accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        d_d         = d_o;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = bus.data_i;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (en_i) begin
                    d_d     = cur_bit;
                    valid_d = 1'b1;
                    last_d  = cnt_last;
                    if (cnt_last) begin
                        cnt_d = '0;
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            shift_d = bus.data_i;
                        end
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        shift_d = shift_adv;
                    end
                end
                // Any accept not consumed directly by the shifter parks in hold
                if (accept && !(last_emit && !hold_full_q)) begin
                    hold_d      = bus.data_i;
                    hold_full_d = 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == S_SHIFT) | hold_full_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            d_o         <= 1'b0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            d_o         <= d_d;
            valid_o     <= valid_d;
            last_o      <= last_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: MSB-first and LSB-first instances.
module tb_bit_stream_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_stream_serializer_if #(.WIDTH(8)) m_if ();
    bit_stream_serializer_if #(.WIDTH(8)) l_if ();

    logic en_m, en_l;
    logic d_m, v_m, l_m, b_m;
    logic d_l, v_l, l_l, b_l;

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .bus(m_if), .en_i(en_m),
        .d_o(d_m), .valid_o(v_m), .last_o(l_m), .busy_o(b_m)
    );

    bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bus(l_if), .en_i(en_l),
        .d_o(d_l), .valid_o(v_l), .last_o(l_l), .busy_o(b_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int   run[2];
    int   last_run[2];
    int   bits_seen[2];
    logic prev_d[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input int which, input logic [7:0] w);
        logic [7:0] ww;
        ww = w;
        for (int i = 0; i < 8; i++) begin
            if (which == 0) q0.push_back({ww[7-i], logic'(i == 7)});
            else            q1.push_back({ww[i],   logic'(i == 7)});
        end
    endtask

    // Present a word; returns at the negedge after it was accepted (load left high)
    task automatic send(input int which, input logic [7:0] w);
        int t;
        logic rdy;
        t = 0;
        if (which == 0) begin m_if.data_i = w; m_if.load_i = 1'b1; end
        else            begin l_if.data_i = w; l_if.load_i = 1'b1; end
        #1;
        rdy = (which == 0) ? m_if.ready_o : l_if.ready_o;
        while (!rdy && t < 100) begin
            @(negedge clk); #1;
            rdy = (which == 0) ? m_if.ready_o : l_if.ready_o;
            t++;
        end
        if (!rdy) check_eq("accept_timeout", 32'(rdy), 32'd1);
        else      push_word(which, w);
        @(negedge clk);
    endtask

    task automatic idle(input int which);
        if (which == 0) m_if.load_i = 1'b0;
        else            l_if.load_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("drain_timeout", 32'(t < 500), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic mon(input int which, input logic d, input logic v, input logic l,
                       input logic b, input logic en, input logic r);
        logic [1:0] e;
        int qs;
        if (r) begin
            check_eq("rst_valid", 32'(v), 32'd0);
            check_eq("rst_busy",  32'(b), 32'd0);
            check_eq("rst_last",  32'(l), 32'd0);
            check_eq("rst_d",     32'(d), 32'd0);
            if (which == 0) q0.delete(); else q1.delete();
            run[which]    = 0;
            prev_d[which] = 1'b0;
            return;
        end
        if (v) begin
            check_eq("valid_on_stall", 32'(en), 32'd1);
            qs = (which == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                check_eq("spurious_valid", 32'(v), 32'd0);
            end else begin
                e = (which == 0) ? q0.pop_front() : q1.pop_front();
                check_eq(which == 0 ? "msb_bit"  : "lsb_bit",  32'(d), 32'(e[1]));
                check_eq(which == 0 ? "msb_last" : "lsb_last", 32'(l), 32'(e[0]));
            end
            run[which]++;
            bits_seen[which]++;
        end else begin
            check_eq("d_hold", 32'(d), 32'(prev_d[which]));
            if (run[which] > 0) last_run[which] = run[which];
            run[which] = 0;
        end
        qs = (which == 0) ? q0.size() : q1.size();
        check_eq(which == 0 ? "msb_busy" : "lsb_busy", 32'(b), 32'(qs != 0));
        prev_d[which] = d;
    endtask

    always begin
        @(posedge clk);
        #1;
        mon(0, d_m, v_m, l_m, b_m, en_m, rst);
        mon(1, d_l, v_l, l_l, b_l, en_l, rst);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int t;
        rst = 1'b1;
        en_m = 1'b1; en_l = 1'b1;
        m_if.load_i = 1'b0; m_if.data_i = '0;
        l_if.load_i = 1'b0; l_if.data_i = '0;
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; last_run[i] = 0; bits_seen[i] = 0; prev_d[i] = 1'b0;
        end
        #1;
        check_eq("ready_in_rst", 32'(m_if.ready_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(m_if.ready_o), 32'd1);
        check_eq("ready_after_rst_lsb", 32'(l_if.ready_o), 32'd1);
        @(negedge clk);

        // Single word, continuous enable
        send(0, 8'h6D); idle(0);
        drain();
        check_eq("t1_run", 32'(last_run[0]), 32'd8);

        // Back-to-back words with load held high
        send(0, 8'hA5);
        send(0, 8'h3C);
        #1;
        check_eq("t2_ready_hold_full", 32'(m_if.ready_o), 32'd0);
        idle(0);
        drain();
        check_eq("t2_run", 32'(last_run[0]), 32'd16);

        // Alternating enable
        send(0, 8'hF0); idle(0);
        t = 0;
        while (q0.size() != 0 && t < 100) begin
            en_m = ~en_m;
            @(negedge clk);
            t++;
        end
        en_m = 1'b1;
        drain();

        // Reset mid-word with hold full
        base = bits_seen[0];
        send(0, 8'hFF);
        send(0, 8'h00);
        idle(0);
        t = 0;
        while (bits_seen[0] - base < 3 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("t4_bits_before_rst", 32'(bits_seen[0] - base), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("t4_ready_in_rst", 32'(m_if.ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("t4_ready_after_rst", 32'(m_if.ready_o), 32'd1);
        @(negedge clk);
        send(0, 8'h81); idle(0);
        drain();

        // LSB-first
        send(1, 8'h01); idle(1);
        drain();
        check_eq("t5_run", 32'(last_run[1]), 32'd8);

        // Accept coinciding with last bit, hold empty
        send(0, 8'hC3); idle(0);
        repeat (7) @(negedge clk);
        send(0, 8'h5A); idle(0);
        drain();
        check_eq("t6_run", 32'(last_run[0]), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
